cpu_regfile_sync_nrmw: RTL and testbench
========================================

# cpu_regfile_sync_nrmw

Parametrised synchronous register file for the AsteRISC core, the successor to the fixed 2-read/1-write regfile. It is generalised in data width, read-port count and write-port count. It adds three things: a reset-time clear sweep that zeroes all architectural registers and reports it on `o_busy`, optional write-to-read bypass, and drop-on-out-of-bounds semantics for the reduced 16-register mode. It sits between decode (read addresses) and writeback (write ports) in every pipeline variant of the core.

## Interface
Parameters:
- `p_width`, 32: data width in bits.
- `p_half_regfile`, 0: when 1, 16 registers instead of 32 (depth `D` = 16 or 32).
- `p_nb_rd`, 2: number of read ports, 1..4.
- `p_nb_wr`, 1: number of write ports, 1..2.
- `p_bypass`, 1: when 1, forward same-cycle write data to read ports.
- `p_clear_on_reset`, 1: when 1, run the zeroing sweep after reset.

Ports:
- `i_clk`  in  1  global clock.
- `i_rst_n`  in  1  global reset, asynchronous, active-low.
- `o_busy`  out  1  clear sweep in progress.
- `o_addr_oob`  out  1  out-of-bounds address seen (half mode only).
- `i_rd_addr`  in  `5*p_nb_rd`  read addresses; port k occupies bits [5k+4:5k].
- `o_rd_data`  out  `p_width*p_nb_rd`  registered read data, packed the same way.
- `i_wr_en`  in  `p_nb_wr`  per-port write enable.
- `i_wr_addr`  in  `5*p_nb_wr`  write addresses.
- `i_wr_data`  in  `p_width*p_nb_wr`  write data.

## Operation
- **Register 0:** hardwired zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0.
- **FSM states:** two, `CLEAR` and `READY`.
  - Reset (async) → `CLEAR` if `p_clear_on_reset`, else `READY`. The sweep counter resets to 1.
  - In `CLEAR`: each clock writes 0 to `regs[cnt]` and increments `cnt`. When `cnt == D-1` is written, go to `READY`.
  - `READY` is terminal until the next reset.
- **Behaviour during `CLEAR`:**
  - `o_busy` = 1.
  - All user writes are dropped, not queued.
  - All read ports return 0.
- **Write ports:**
  - A write to port j takes effect on the rising edge when all of these hold: `i_wr_en[j]`, `addr != 0`, the address is in bounds, and the state is `READY`.
  - Both ports writing the same address in the same cycle: port 1 wins, and port 0's data is lost.
- **Read ports:** every port samples every cycle. `o_rd_data[k]` is updated on each edge from `regs[addr_k]`.
  - With `p_bypass` = 1: if any effective write in the same cycle targets `addr_k`, the read takes that write data instead. Port-1 priority applies.
  - With `p_bypass` = 0: the read returns the pre-write (old) value.
- **Half mode:**
  - Any address with bit 4 set is out of bounds.
  - An out-of-bounds write is dropped; it is not aliased.
  - An out-of-bounds read returns 0.
  - `o_addr_oob` is combinational: the OR over read ports of `addr[4]`, and over write ports of `i_wr_en & addr[4]`.
  - In full mode `o_addr_oob` = 0 constantly.
- **Storage:** intended for distributed RAM. The memory array has no reset; only the sweep clears it.

## Timing
- **Reset values:** `o_rd_data` = 0 on all ports; `o_busy` = `p_clear_on_reset` (asynchronously, on `i_rst_n` low).
- **Read latency:** 1 cycle. Address presented before edge N; data valid after edge N.
- **Write visibility:**
  - Without bypass, a written value is readable on the edge after the write edge.
  - With bypass, it is readable on the write edge itself.
- **Sweep duration:** after `i_rst_n` rises, `o_busy` stays high for exactly D-1 rising edges (31, or 15 in half mode) and falls on the last of them.
  - The first accepted write is the edge after `o_busy` is sampled low.
  - Reads issued in the same cycle as that first accepted write return real contents.
- **Reset mid-sweep or mid-operation:** async restart. The state returns to `CLEAR` and the counter to 1, so the full sweep runs again.
  - A write whose edge coincides with reset assertion is discarded.
- `o_busy` is driven directly from the state register, with no combinational path from the inputs.

## Test plan
- **Reset sweep:** `p_clear_on_reset`=1, full mode. Preload x5 with 0xDEADBEEF, pulse `i_rst_n` low, then release → `o_busy` high for exactly 31 edges. Afterwards a read of x5 returns 0, and a write issued during busy to x7=0x1234 reads back 0.
- **Basic write/read, bypass on vs off:**
  - Write x3=0xA5A5A5A5 while port 0 reads x3 in the same cycle. `p_bypass`=1 → 0xA5A5A5A5 next cycle. `p_bypass`=0 → old value, then 0xA5A5A5A5 one cycle later.
  - Writing x0=0xFFFFFFFF → reads of x0 return 0.
- **Dual-write conflict:** `p_nb_wr`=2. In one cycle, port 0 writes x9=0x11 and port 1 writes x9=0x22 → x9 reads 0x22 on all read ports. A simultaneous bypass read of x9 also shows 0x22.
- **Half mode OOB:** `p_half_regfile`=1.
  - Write x20=0x55 → `o_addr_oob`=1 in that cycle; x4 is unchanged (no aliasing).
  - Read of x17 → `o_addr_oob`=1 and data 0.
  - Write x15=0x77 → reads 0x77 with `o_addr_oob`=0.
- **Reset mid-sweep:** assert `i_rst_n` low for 1 cycle at sweep edge 10 → `o_busy` remains high for a further full 31 edges counted from the new release.
- **Multi-port read:** `p_nb_rd`=4, `p_width`=64. Write x1..x4 with distinct 64-bit patterns, then read x4,x3,x2,x1 on ports 0..3 simultaneously → each port returns its pattern after 1 cycle with no cross-port corruption.

Source files
------------

// File: rtl/cpu_regfile_sync_nrmw_if.sv
// Decode/writeback bus of the AsteRISC register file: packed read and write ports.
// Port k of a packed field occupies slice [W*k +: W].
interface cpu_regfile_sync_nrmw_if #(
  parameter int unsigned p_width = 32,
  parameter int unsigned p_nb_rd = 2,
  parameter int unsigned p_nb_wr = 1
);
  logic [5*p_nb_rd-1:0]       i_rd_addr;
  logic [p_width*p_nb_rd-1:0] o_rd_data;
  logic [p_nb_wr-1:0]         i_wr_en;
  logic [5*p_nb_wr-1:0]       i_wr_addr;
  logic [p_width*p_nb_wr-1:0] i_wr_data;

  modport master (
    output i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
    input  o_rd_data
  );

  modport slave (
    input  i_rd_addr, i_wr_en, i_wr_addr, i_wr_data,
    output o_rd_data
  );
endinterface

// File: rtl/cpu_regfile_sync_nrmw.sv
// Parametrised AsteRISC register file: N read / M write ports, x0 hardwired to zero,
// post-reset zeroing sweep, optional write-to-read bypass and a 16-entry half mode.
module cpu_regfile_sync_nrmw #(
  parameter int unsigned p_width          = 32,
  parameter int unsigned p_half_regfile   = 0,
  parameter int unsigned p_nb_rd          = 2,
  parameter int unsigned p_nb_wr          = 1,
  parameter int unsigned p_bypass         = 1,
  parameter int unsigned p_clear_on_reset = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_busy,
  output logic                   o_addr_oob,
  cpu_regfile_sync_nrmw_if.slave bus
);
  localparam int unsigned Depth   = (p_half_regfile != 0) ? 16 : 32;
  localparam int unsigned Aw      = (p_half_regfile != 0) ? 4 : 5;
  localparam logic [4:0]  LastIdx = 5'(Depth - 1);

  typedef enum logic [0:0] {StClear = 1'b0, StReady = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;

  logic [p_nb_rd-1:0][4:0]         rd_addr;
  logic [p_nb_wr-1:0]              wr_en;
  logic [p_nb_wr-1:0][4:0]         wr_addr;
  logic [p_nb_wr-1:0][p_width-1:0] wr_data;
  logic [p_nb_wr-1:0]              wr_eff;
  logic [p_nb_rd-1:0][p_width-1:0] rd_data_q, rd_data_d;
  logic                            addr_oob;

  // Distributed-RAM storage: deliberately unreset, only the sweep clears it.
  logic [p_width-1:0] regs_q [Depth];

  assign rd_addr       = bus.i_rd_addr;
  assign wr_en         = bus.i_wr_en;
  assign wr_addr       = bus.i_wr_addr;
  assign wr_data       = bus.i_wr_data;
  assign bus.o_rd_data = rd_data_q;
  assign o_busy        = (state_q == StClear);

  function automatic logic in_bounds(input logic [4:0] addr);
    return (p_half_regfile == 0) || !addr[4];
  endfunction

  always_comb begin
    addr_oob = 1'b0;
    for (int k = 0; k < p_nb_rd; k++) addr_oob = addr_oob | rd_addr[k][4];
    for (int j = 0; j < p_nb_wr; j++) addr_oob = addr_oob | (wr_en[j] & wr_addr[j][4]);
  end

  assign o_addr_oob = (p_half_regfile != 0) ? addr_oob : 1'b0;

  always_comb begin
    for (int j = 0; j < p_nb_wr; j++) begin
      wr_eff[j] = wr_en[j] && (wr_addr[j] != 5'd0) && in_bounds(wr_addr[j]) &&
                  (state_q == StReady);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StClear) begin
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LastIdx) state_d = StReady;
    end
  end

  // Ascending port order lets the highest-numbered write port win both here and in RAM.
  always_comb begin
    for (int k = 0; k < p_nb_rd; k++) begin
      rd_data_d[k] = '0;
      if (state_q == StReady && rd_addr[k] != 5'd0 && in_bounds(rd_addr[k])) begin
        rd_data_d[k] = regs_q[rd_addr[k][Aw-1:0]];
        if (p_bypass != 0) begin
          for (int j = 0; j < p_nb_wr; j++) begin
            if (wr_eff[j] && wr_addr[j] == rd_addr[k]) rd_data_d[k] = wr_data[j];
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= (p_clear_on_reset != 0) ? StClear : StReady;
      cnt_q     <= 5'd1;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == StClear) begin
      regs_q[cnt_q[Aw-1:0]] <= '0;
    end else begin
      for (int j = 0; j < p_nb_wr; j++) begin
        if (wr_eff[j]) regs_q[wr_addr[j][Aw-1:0]] <= wr_data[j];
      end
    end
  end
endmodule

// File: tb/tb_cpu_regfile_sync_nrmw.sv
// Bench for cpu_regfile_sync_nrmw: DUT A (32b, full, 2R/2W, bypass) and
// DUT B (64b, half mode, 4R/1W, no bypass) checked against a per-edge memory model.
module tb_cpu_regfile_sync_nrmw;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // DUT A stimulus
  logic [1:0]       a_we;
  logic [1:0][4:0]  a_wa;
  logic [1:0][31:0] a_wd;
  logic [1:0][4:0]  a_ra;
  logic             busy_a, oob_a;
  // DUT B stimulus
  logic             b_we;
  logic [4:0]       b_wa;
  logic [63:0]      b_wd;
  logic [3:0][4:0]  b_ra;
  logic             busy_b, oob_b;

  cpu_regfile_sync_nrmw_if #(.p_width(32), .p_nb_rd(2), .p_nb_wr(2)) bus_a ();
  cpu_regfile_sync_nrmw_if #(.p_width(64), .p_nb_rd(4), .p_nb_wr(1)) bus_b ();

  assign bus_a.i_wr_en   = a_we;
  assign bus_a.i_wr_addr = a_wa;
  assign bus_a.i_wr_data = a_wd;
  assign bus_a.i_rd_addr = a_ra;
  assign bus_b.i_wr_en   = b_we;
  assign bus_b.i_wr_addr = b_wa;
  assign bus_b.i_wr_data = b_wd;
  assign bus_b.i_rd_addr = b_ra;

  cpu_regfile_sync_nrmw #(
    .p_width(32), .p_half_regfile(0), .p_nb_rd(2), .p_nb_wr(2),
    .p_bypass(1), .p_clear_on_reset(1)
  ) u_dut_a (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .o_busy     (busy_a),
    .o_addr_oob (oob_a),
    .bus        (bus_a)
  );

  cpu_regfile_sync_nrmw #(
    .p_width(64), .p_half_regfile(1), .p_nb_rd(4), .p_nb_wr(1),
    .p_bypass(0), .p_clear_on_reset(1)
  ) u_dut_b (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .o_busy     (busy_b),
    .o_addr_oob (oob_b),
    .bus        (bus_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: architectural contents plus expected registered read data.
  logic [31:0] ma [32];
  logic [63:0] mb [16];
  logic [31:0] ea [2];
  logic [63:0] eb [4];
  int          a_left, b_left;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) ma[i] = '0;
    for (int i = 0; i < 16; i++) mb[i] = '0;
    for (int k = 0; k < 2; k++) ea[k] = '0;
    for (int k = 0; k < 4; k++) eb[k] = '0;
    a_left = 31;
    b_left = 15;
  endtask

  // One rising edge: A reads see the post-write file (bypass), B reads see the pre-write file.
  task automatic model_edge();
    if (a_left > 0) begin
      a_left--;
      for (int k = 0; k < 2; k++) ea[k] = '0;
    end else begin
      for (int j = 0; j < 2; j++) if (a_we[j] && a_wa[j] != 0) ma[a_wa[j]] = a_wd[j];
      for (int k = 0; k < 2; k++) ea[k] = (a_ra[k] == 0) ? 32'h0 : ma[a_ra[k]];
    end
    if (b_left > 0) begin
      b_left--;
      for (int k = 0; k < 4; k++) eb[k] = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        eb[k] = (b_ra[k] == 0 || b_ra[k] >= 16) ? 64'h0 : mb[b_ra[k][3:0]];
      end
      if (b_we && b_wa != 0 && b_wa < 16) mb[b_wa[3:0]] = b_wd;
    end
  endtask

  function automatic logic exp_oob_b();
    logic r;
    r = b_we & (b_wa >= 16);
    for (int k = 0; k < 4; k++) r = r | (b_ra[k] >= 16);
    return r;
  endfunction

  task automatic check_outputs();
    chk("a_busy", busy_a, a_left > 0);
    chk("a_oob", oob_a, 1'b0);
    for (int k = 0; k < 2; k++) chk($sformatf("a_rd%0d", k), bus_a.o_rd_data[32*k +: 32], ea[k]);
    chk("b_busy", busy_b, b_left > 0);
    chk("b_oob", oob_b, exp_oob_b());
    for (int k = 0; k < 4; k++) chk($sformatf("b_rd%0d", k), bus_b.o_rd_data[64*k +: 64], eb[k]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    a_we = '0; a_wa = '0; a_wd = '0; a_ra = '0;
    b_we = 1'b0; b_wa = '0; b_wd = '0; b_ra = '0;
  endtask

  // Assert reset over exactly one rising edge, checking the asynchronous values.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Count edges until each o_busy falls; optionally attempt writes to x7 while busy.
  task automatic count_busy(input bit poke);
    int na = 0;
    int nb = 0;
    if (poke) begin
      a_we = 2'b01; a_wa[0] = 5'd7; a_wd[0] = 32'h1234;
      b_we = 1'b1;  b_wa = 5'd7;    b_wd = 64'h1234;
    end
    for (int i = 1; i <= 100 && (na == 0 || nb == 0); i++) begin
      cycle();
      if (na == 0 && busy_a !== 1'b1) begin na = i; a_we = '0; end
      if (nb == 0 && busy_b !== 1'b1) begin nb = i; b_we = 1'b0; end
    end
    chk("a_sweep_edges", 64'(na), 64'd31);
    chk("b_sweep_edges", 64'(nb), 64'd15);
  endtask

  function automatic logic [4:0] pick_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
  endfunction

  typedef struct {
    logic [1:0]  a_we;
    logic [4:0]  a_wa0;
    logic [31:0] a_wd0;
    logic [4:0]  a_wa1;
    logic [31:0] a_wd1;
    logic [4:0]  a_ra0;
    logic [4:0]  a_ra1;
    logic        b_we;
    logic [4:0]  b_wa;
    logic [63:0] b_wd;
    logic [4:0]  b_ra0;
    logic [31:0] x_a0;
    logic [31:0] x_a1;
    logic [63:0] x_b0;
    logic        x_oob;
  } vec_t;

  vec_t        tbl [12];
  logic [63:0] pat [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'b01, 5'd3,  32'hA5A5A5A5, 5'd0,  32'h0,        5'd3,  5'd3,
                1'b1, 5'd3,  64'hA5A5A5A5A5A5A5A5, 5'd3,
                32'hA5A5A5A5, 32'hA5A5A5A5, 64'h0, 1'b0};
    tbl[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd3,  5'd0,
                1'b0, 5'd0,  64'h0, 5'd3,
                32'hA5A5A5A5, 32'h0, 64'hA5A5A5A5A5A5A5A5, 1'b0};
    tbl[2]  = '{2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,        5'd0,  5'd0,
                1'b1, 5'd0,  64'hFFFFFFFFFFFFFFFF, 5'd0,
                32'h0, 32'h0, 64'h0, 1'b0};
    tbl[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd0,  5'd3,
                1'b0, 5'd0,  64'h0, 5'd0,
                32'h0, 32'hA5A5A5A5, 64'h0, 1'b0};
    tbl[4]  = '{2'b11, 5'd9,  32'h11,       5'd9,  32'h22,       5'd9,  5'd9,
                1'b1, 5'd4,  64'h44, 5'd4,
                32'h22, 32'h22, 64'h0, 1'b0};
    tbl[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd9,
                1'b1, 5'd20, 64'h55, 5'd4,
                32'h22, 32'h22, 64'h44, 1'b1};
    tbl[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd9,  5'd3,
                1'b0, 5'd0,  64'h0, 5'd4,
                32'h22, 32'hA5A5A5A5, 64'h44, 1'b0};
    tbl[7]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd1,  5'd2,
                1'b0, 5'd0,  64'h0, 5'd17,
                32'h0, 32'h0, 64'h0, 1'b1};
    tbl[8]  = '{2'b10, 5'd31, 32'h1,        5'd31, 32'hCAFEF00D, 5'd31, 5'd30,
                1'b1, 5'd15, 64'h77, 5'd15,
                32'hCAFEF00D, 32'h0, 64'h0, 1'b0};
    tbl[9]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd31, 5'd0,
                1'b0, 5'd0,  64'h0, 5'd15,
                32'hCAFEF00D, 32'h0, 64'h77, 1'b0};
    tbl[10] = '{2'b11, 5'd5,  32'h55,       5'd6,  32'h66,       5'd5,  5'd6,
                1'b0, 5'd0,  64'h0, 5'd3,
                32'h55, 32'h66, 64'hA5A5A5A5A5A5A5A5, 1'b0};
    tbl[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        5'd6,  5'd5,
                1'b0, 5'd0,  64'h0, 5'd31,
                32'h66, 32'h55, 64'h0, 1'b1};
    pat[0] = 64'h1111_2222_3333_4444;
    pat[1] = 64'h5555_6666_7777_8888;
    pat[2] = 64'h9999_AAAA_BBBB_CCCC;
    pat[3] = 64'hDDDD_EEEE_FFFF_0001;

    idle();
    rst_n = 1'b1;
    #2;
    do_reset();
    count_busy(1'b1);
    idle();

    // Directed vectors with hand-derived expectations.
    for (int i = 0; i < 12; i++) begin
      a_we = tbl[i].a_we;
      a_wa[0] = tbl[i].a_wa0; a_wd[0] = tbl[i].a_wd0;
      a_wa[1] = tbl[i].a_wa1; a_wd[1] = tbl[i].a_wd1;
      a_ra[0] = tbl[i].a_ra0; a_ra[1] = tbl[i].a_ra1;
      b_we = tbl[i].b_we; b_wa = tbl[i].b_wa; b_wd = tbl[i].b_wd;
      b_ra = '0; b_ra[0] = tbl[i].b_ra0;
      #1;
      chk($sformatf("tbl%0d_b_oob", i), oob_b, tbl[i].x_oob);
      cycle();
      chk($sformatf("tbl%0d_a_rd0", i), bus_a.o_rd_data[31:0], tbl[i].x_a0);
      chk($sformatf("tbl%0d_a_rd1", i), bus_a.o_rd_data[63:32], tbl[i].x_a1);
      chk($sformatf("tbl%0d_b_rd0", i), bus_b.o_rd_data[63:0], tbl[i].x_b0);
    end
    idle();

    // Four simultaneous 64-bit reads in reverse order.
    for (int i = 1; i <= 4; i++) begin
      b_we = 1'b1; b_wa = 5'(i); b_wd = pat[i-1];
      cycle();
    end
    idle();
    for (int k = 0; k < 4; k++) b_ra[k] = 5'(4 - k);
    cycle();
    for (int k = 0; k < 4; k++) chk($sformatf("mport_rd%0d", k), bus_b.o_rd_data[64*k +: 64],
                                    pat[3-k]);
    idle();

    // Preload x5, reset, then confirm the sweep wiped it and dropped busy-time writes.
    a_we = 2'b01; a_wa[0] = 5'd5; a_wd[0] = 32'hDEADBEEF;
    b_we = 1'b1;  b_wa = 5'd5;    b_wd = 64'hDEADBEEF;
    cycle();
    idle();
    a_ra[0] = 5'd5; b_ra[0] = 5'd5;
    cycle();
    chk("preload_a_x5", bus_a.o_rd_data[31:0], 32'hDEADBEEF);
    idle();
    do_reset();
    count_busy(1'b1);
    idle();
    a_ra[0] = 5'd5; a_ra[1] = 5'd7;
    b_ra[0] = 5'd5; b_ra[1] = 5'd7;
    cycle();
    chk("post_sweep_a_x5", bus_a.o_rd_data[31:0], 32'h0);
    chk("post_sweep_a_x7", bus_a.o_rd_data[63:32], 32'h0);
    chk("post_sweep_b_x5", bus_b.o_rd_data[63:0], 64'h0);
    idle();

    // Reset again part-way through the sweep: the full sweep must restart.
    do_reset();
    for (int i = 0; i < 10; i++) cycle();
    do_reset();
    count_busy(1'b0);

    // Random traffic from reset, so busy-time drops are exercised too.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int j = 0; j < 2; j++) begin
        a_wa[j] = pick_addr();
        a_wd[j] = $urandom;
        a_ra[j] = pick_addr();
      end
      a_we = 2'($urandom);
      b_we = 1'($urandom);
      b_wa = pick_addr();
      b_wd = {$urandom, $urandom};
      for (int k = 0; k < 4; k++) b_ra[k] = pick_addr();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
